adc_lane_aligner: RTL and testbench

ADC_LANE_ALIGNER -- requirements
Module: adc_lane_aligner

---
 rtl/adc_lane_aligner.sv | 145 ++++++++++++++
 tb/tb_adc_lane_aligner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_lane_aligner.sv
// Frame-word aligner for a bank of two-lane serial ADC channels: bitslips until the frame word matches, then emits samples.
// Optional macro ADC_LOSS_MONITOR_EN: drop lock and re-align after LOSS_THRESH consecutive frame mismatches.

module adc_lane_sample #(
  parameter int SER_W    = 8,
  parameter int SAMPLE_W = 14
) (
  input  logic                  adc_clk,
  input  logic                  cpu_resetn,
  input  logic                  take,
  input  logic [2*SER_W-1:0]    word,
  output logic [SAMPLE_W-1:0]   sample
);
  localparam int SHIFT = 2*SER_W - SAMPLE_W;

  logic [2*SER_W-1:0] shifted;
  assign shifted = word >> SHIFT;

  always_ff @(posedge adc_clk or negedge cpu_resetn) begin
    if (!cpu_resetn)  sample <= '0;
    else if (take)    sample <= shifted[SAMPLE_W-1:0];
  end
endmodule

module adc_lane_aligner #(
  parameter int          NUM_CH        = 2,
  parameter int          SER_W         = 8,
  parameter int          SAMPLE_W      = 14,
  parameter logic [7:0]  FRAME_PATTERN = 8'hF0,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          LOSS_THRESH   = 3
) (
  input  logic                           adc_clk,
  input  logic                           cpu_resetn,
  input  logic                           adc_en,
  input  logic [SER_W-1:0]               frm_data,
  input  logic [NUM_CH*2*SER_W-1:0]      lane_data,
  output logic                           bitslip,
  output logic                           aligned,
  output logic                           align_fail,
  output logic [4:0]                     slip_count,
  output logic [NUM_CH*SAMPLE_W-1:0]     samples,
  output logic                           sample_valid
);
  localparam int SLIP_MAX = 2*SER_W;
  localparam int SLW      = $clog2(SLIP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_FAIL
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         settle_cnt;
  logic [SLW-1:0]     slips;
  logic               frm_match;
  logic               restart;
  logic               take;

  assign frm_match = (frm_data == SER_W'(FRAME_PATTERN));

`ifdef ADC_LOSS_MONITOR_EN
  logic [3:0] mis_cnt;
`endif

  always_comb begin
    state_nxt = state;
    if (!adc_en) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_CHECK;
        // A match on the final permitted check still wins over giving up
        S_CHECK:  if (frm_match)                      state_nxt = S_LOCKED;
                  else if (slips < SLW'(SLIP_MAX))    state_nxt = S_SLIP;
                  else                                state_nxt = S_FAIL;
        // The slip cycle counts as the first settle cycle, so pulses sit SETTLE_CYCLES+1 apart
        S_SLIP:   state_nxt = (SETTLE_CYCLES <= 1) ? S_CHECK : S_SETTLE;
        S_SETTLE: if (settle_cnt == 4'(SETTLE_CYCLES - 2)) state_nxt = S_CHECK;
`ifdef ADC_LOSS_MONITOR_EN
        S_LOCKED: if (!frm_match && mis_cnt == 4'(LOSS_THRESH - 1)) state_nxt = S_CHECK;
`else
        S_LOCKED: state_nxt = S_LOCKED;
`endif
        S_FAIL:   state_nxt = S_FAIL;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  assign restart = (state_nxt == S_CHECK) && (state == S_IDLE || state == S_LOCKED);

  always_ff @(posedge adc_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      slips      <= '0;
      slip_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_SLIP)        settle_cnt <= '0;
      else if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      if (restart) begin
        slips      <= '0;
        slip_count <= '0;
      end else if (state_nxt == S_SLIP) begin
        slips <= slips + SLW'(1);
        if (slip_count != 5'd31) slip_count <= slip_count + 5'd1;
      end
    end
  end

`ifdef ADC_LOSS_MONITOR_EN
  always_ff @(posedge adc_clk or negedge cpu_resetn) begin
    if (!cpu_resetn)                                   mis_cnt <= '0;
    else if (state == S_LOCKED && state_nxt == S_LOCKED) mis_cnt <= frm_match ? 4'd0 : mis_cnt + 4'd1;
    else                                               mis_cnt <= '0;
  end
`endif

  assign bitslip    = (state == S_SLIP);
  assign aligned    = (state == S_LOCKED);
  assign align_fail = (state == S_FAIL);

  // Only words captured while locked and staying locked are published
  assign take = (state == S_LOCKED) && (state_nxt == S_LOCKED);

  always_ff @(posedge adc_clk or negedge cpu_resetn) begin
    if (!cpu_resetn) sample_valid <= 1'b0;
    else             sample_valid <= take;
  end

  logic [NUM_CH-1:0][SAMPLE_W-1:0] smp;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adc_lane_sample #(.SER_W(SER_W), .SAMPLE_W(SAMPLE_W)) u_lane (
      .adc_clk    (adc_clk),
      .cpu_resetn (cpu_resetn),
      .take       (take),
      .word       (lane_data[2*c*SER_W +: 2*SER_W]),
      .sample     (smp[c])
    );
  end

  assign samples = smp;
endmodule

// File: tb/tb_adc_lane_aligner.sv
// Directed bench for adc_lane_aligner: lock, slip cadence, fail, sample path, loss monitor, reset.
module tb_adc_lane_aligner;
  localparam logic [7:0] PAT = 8'hF0;

  logic        adc_clk = 1'b0;
  logic        cpu_resetn;
  logic        adc_en;
  logic [7:0]  frm_data;
  logic [31:0] lane_data;
  logic        bitslip, aligned, align_fail, sample_valid;
  logic [4:0]  slip_count;
  logic [27:0] samples;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, pulse_cnt = 0, pulse_base = 0;
  int pulse_cyc [64];
  int frm_mode = 0, rot_init = 0;
  logic [7:0] frm_fix = 8'h00;

  adc_lane_aligner dut (
    .adc_clk      (adc_clk),
    .cpu_resetn   (cpu_resetn),
    .adc_en       (adc_en),
    .frm_data     (frm_data),
    .lane_data    (lane_data),
    .bitslip      (bitslip),
    .aligned      (aligned),
    .align_fail   (align_fail),
    .slip_count   (slip_count),
    .samples      (samples),
    .sample_valid (sample_valid)
  );

  always #5 adc_clk = ~adc_clk;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int r);
    logic [15:0] t;
    t = {x, x} << r;
    return t[15:8];
  endfunction

  // Deserializer model: each bitslip pulse undoes one bit of rotation
  always_comb begin : frm_gen
    int n;
    n = pulse_cnt - pulse_base;
    case (frm_mode)
      1:       frm_data = rotl8(PAT, (rot_init - n) & 7);
      2:       frm_data = (n >= 16) ? PAT : 8'h00;
      default: frm_data = frm_fix;
    endcase
  end

  always @(negedge adc_clk) begin
    cyc <= cyc + 1;
    if (bitslip) begin
      pulse_cyc[pulse_cnt % 64] <= cyc;
      pulse_cnt <= pulse_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_sig(input int sel, input int max_cyc, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge adc_clk);
      case (sel)
        0:       hit = aligned;
        1:       hit = align_fail;
        default: hit = bitslip;
      endcase
    end
    check(tag, 32'(hit), 1);
  endtask

  task automatic start();
    adc_en = 1'b0;
    repeat (2) @(negedge adc_clk);
    pulse_base = pulse_cnt;
    adc_en = 1'b1;
  endtask

  initial begin
    cpu_resetn = 1'b0;
    adc_en     = 1'b0;
    lane_data  = '0;
    repeat (2) @(negedge adc_clk);
    check("rst_aligned", 32'(aligned), 0);
    check("rst_bitslip", 32'(bitslip), 0);
    check("rst_slip_count", 32'(slip_count), 0);
    check("rst_samples", 32'(samples), 0);
    check("rst_valid", 32'(sample_valid), 0);
    cpu_resetn = 1'b1;

    // Frame already correct: lock on the second edge, no slips
    frm_mode = 0; frm_fix = PAT;
    start();
    @(negedge adc_clk);
    check("lock_cyc1", 32'(aligned), 0);
    @(negedge adc_clk);
    check("lock_cyc2", 32'(aligned), 1);
    check("lock_slip_count", 32'(slip_count), 0);
    check("lock_first_valid", 32'(sample_valid), 0);
    @(negedge adc_clk);
    check("lock_valid", 32'(sample_valid), 1);
    check("lock_no_pulse", 32'(pulse_cnt - pulse_base), 0);

    // Sample extraction: {lane0,lane1} >> 2
    lane_data = 32'h1234_ABCD;
    @(negedge adc_clk);
    check("smp_ch0", 32'(samples[13:0]), 32'h2AF3);
    check("smp_ch1", 32'(samples[27:14]), 32'h048D);
    check("smp_valid", 32'(sample_valid), 1);
    lane_data = 32'h0003_FFFF;
    @(negedge adc_clk);
    check("smp_ch0_max", 32'(samples[13:0]), 32'h3FFF);
    check("smp_ch1_low", 32'(samples[27:14]), 32'h0000);
    adc_en = 1'b0;
    lane_data = 32'h5555_5555;
    @(negedge adc_clk);
    check("dis_valid", 32'(sample_valid), 0);
    check("dis_aligned", 32'(aligned), 0);
    check("dis_hold", 32'(samples[13:0]), 32'h3FFF);

    // Frame rotated 3 bits
    frm_mode = 1; rot_init = 3;
    start();
    wait_sig(0, 100, "rot_lock_timeout");
    check("rot_slip_count", 32'(slip_count), 3);
    check("rot_pulses", 32'(pulse_cnt - pulse_base), 3);
    check("rot_gap1", 32'(pulse_cyc[(pulse_base + 1) % 64] - pulse_cyc[pulse_base % 64]), 5);
    check("rot_gap2", 32'(pulse_cyc[(pulse_base + 2) % 64] - pulse_cyc[(pulse_base + 1) % 64]), 5);

    // Frame stuck at zero: 16 slips then fail
    frm_mode = 0; frm_fix = 8'h00;
    start();
    wait_sig(1, 300, "fail_timeout");
    check("fail_slip_count", 32'(slip_count), 16);
    check("fail_pulses", 32'(pulse_cnt - pulse_base), 16);
    check("fail_aligned", 32'(aligned), 0);
    check("fail_valid", 32'(sample_valid), 0);
    repeat (10) @(negedge adc_clk);
    check("fail_no_more_pulses", 32'(pulse_cnt - pulse_base), 16);
    check("fail_sticky", 32'(align_fail), 1);
    adc_en = 1'b0;
    @(negedge adc_clk);
    check("fail_cleared", 32'(align_fail), 0);

    // Match appears exactly on the last allowed check
    frm_mode = 2;
    start();
    wait_sig(0, 300, "late_lock_timeout");
    check("late_no_fail", 32'(align_fail), 0);
    check("late_slip_count", 32'(slip_count), 16);

    frm_mode = 0; frm_fix = PAT;
    @(negedge adc_clk);
`ifdef ADC_LOSS_MONITOR_EN
    frm_fix = 8'h00;
    @(negedge adc_clk);
    check("loss_mis1", 32'(aligned), 1);
    @(negedge adc_clk);
    check("loss_mis2", 32'(aligned), 1);
    @(negedge adc_clk);
    check("loss_mis3", 32'(aligned), 0);
    check("loss_slip_clr", 32'(slip_count), 0);
    check("loss_valid", 32'(sample_valid), 0);
    @(negedge adc_clk);
    check("loss_realign_slip", 32'(bitslip), 1);
    frm_fix = PAT;
    wait_sig(0, 60, "loss_relock_timeout");
    frm_fix = 8'h00;
    repeat (2) @(negedge adc_clk);
    frm_fix = PAT;
    @(negedge adc_clk);
    frm_fix = 8'h00;
    repeat (2) @(negedge adc_clk);
    check("loss_cnt_cleared", 32'(aligned), 1);
    frm_fix = PAT;
`else
    frm_fix = 8'h00;
    repeat (6) @(negedge adc_clk);
    check("hold_aligned", 32'(aligned), 1);
    check("hold_valid", 32'(sample_valid), 1);
    frm_fix = PAT;
`endif

    // Async reset in the middle of a settle window
    frm_mode = 0; frm_fix = 8'h00;
    start();
    wait_sig(2, 20, "rst_slip_timeout");
    @(negedge adc_clk);
    check("settle_slip_count", 32'(slip_count), 1);
    #2 cpu_resetn = 1'b0;
    #1;
    check("arst_bitslip", 32'(bitslip), 0);
    check("arst_slip_count", 32'(slip_count), 0);
    check("arst_samples", 32'(samples), 0);
    check("arst_valid", 32'(sample_valid), 0);
    check("arst_fail", 32'(align_fail), 0);
    adc_en = 1'b0;
    @(negedge adc_clk);
    cpu_resetn = 1'b1;
    repeat (3) @(negedge adc_clk);
    check("post_rst_bitslip", 32'(bitslip), 0);
    frm_fix = PAT;
    adc_en = 1'b1;
    @(negedge adc_clk);
    check("post_rst_cyc1", 32'(aligned), 0);
    @(negedge adc_clk);
    check("post_rst_cyc2", 32'(aligned), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
